// File: rtl/spi2apb_bridge_p.sv
// SPI slave frame engine running one APB3 master transfer per fixed-length frame.
// Ports: sclk/resetn/ss/mosi/miso SPI side; b_* APB master side (b_pclk = sclk); err = last status.
module spi2apb_bridge_p #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 4
) (
  input  logic              sclk,
  input  logic              resetn,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              b_pclk,
  output logic              b_resetn,
  output logic [ADDR_W-1:0] b_paddr,
  output logic [DATA_W-1:0] b_pwdata,
  output logic              b_pwrite,
  output logic              b_psel,
  output logic              b_penable,
  input  logic [DATA_W-1:0] b_prdata,
  input  logic              b_pready,
  input  logic              b_pslverr,
  output logic              err
);

  localparam int FL = 1 + ADDR_W + DATA_W + WAIT_CYC;
  localparam int EA = 1 + ADDR_W;
  localparam int ED = EA + DATA_W;
  localparam int CW = $clog2(FL + 2);

  localparam logic [CW-1:0] C_FL = CW'(FL);
  localparam logic [CW-1:0] C_EA = CW'(EA);
  localparam logic [CW-1:0] C_ED = CW'(ED);
  localparam logic [CW-1:0] C_RL = CW'(EA + WAIT_CYC);
  localparam logic [CW-1:0] C_WT = CW'(ED + WAIT_CYC);

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, WDATA, SETUP,
    ACCESS, RDATA, TAIL, DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     e;
  logic              rw;
  logic [ADDR_W-1:0] ash;
  logic [DATA_W-2:0] dsh;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rsh;
  logic [ADDR_W-1:0] a_nxt;
  logic [DATA_W-1:0] d_nxt;
  logic [DATA_W-1:0] ld;
  logic              psel_q;
  logic              pen_q;
  logic              tmo;

  // e is the 1-based index of the edge being taken now
  assign e     = cnt + CW'(1);
  assign a_nxt = {ash[ADDR_W-2:0], mosi};
  assign d_nxt = {dsh, mosi};
  assign tmo   = (e == (rw ? C_WT : C_RL));
  // miso word when completion and the miso load share an edge
  assign ld    = b_pready ? b_prdata : '1;

  assign b_pclk    = sclk;
  assign b_resetn  = resetn;
  assign b_psel    = psel_q & ~ss;
  assign b_penable = pen_q & ~ss;

  always_ff @(posedge sclk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      rw       <= 1'b0;
      ash      <= '0;
      dsh      <= '0;
      rdata    <= '0;
      rsh      <= '0;
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      miso     <= 1'b0;
      b_paddr  <= '0;
      b_pwdata <= '0;
      b_pwrite <= 1'b0;
      err      <= 1'b0;
    end else if (ss) begin
      if (state == SETUP || state == ACCESS)
        err <= 1'b1;
      state  <= IDLE;
      cnt    <= '0;
      psel_q <= 1'b0;
      pen_q  <= 1'b0;
      miso   <= 1'b0;
    end else begin
      if (cnt != C_FL)
        cnt <= e;
      miso <= 1'b0;
      unique case (state)
        IDLE: begin
          rw    <= mosi;
          state <= CMD;
        end
        CMD, ADDR: begin
          ash <= a_nxt;
          if (e == C_EA) begin
            if (rw) begin
              state <= WDATA;
            end else begin
              b_paddr  <= a_nxt;
              b_pwrite <= 1'b0;
              psel_q   <= 1'b1;
              state    <= SETUP;
            end
          end else begin
            state <= ADDR;
          end
        end
        WDATA: begin
          dsh <= d_nxt[DATA_W-2:0];
          if (e == C_ED) begin
            b_paddr  <= ash;
            b_pwdata <= d_nxt;
            b_pwrite <= 1'b1;
            psel_q   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          pen_q <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: begin
          if (b_pready || tmo) begin
            psel_q <= 1'b0;
            pen_q  <= 1'b0;
            err    <= b_pready ? b_pslverr : 1'b1;
            rdata  <= ld;
            if (!rw && e == C_RL) begin
              miso  <= ld[DATA_W-1];
              rsh   <= {ld[DATA_W-2:0], 1'b0};
              state <= RDATA;
            end else if (e == C_FL) begin
              state <= DONE;
            end else begin
              state <= TAIL;
            end
          end
        end
        TAIL: begin
          if (!rw && e == C_RL) begin
            miso  <= rdata[DATA_W-1];
            rsh   <= {rdata[DATA_W-2:0], 1'b0};
            state <= RDATA;
          end else if (e == C_FL) begin
            state <= DONE;
          end
        end
        RDATA: begin
          if (e == C_FL) begin
            state <= DONE;
          end else begin
            miso <= rsh[DATA_W-1];
            rsh  <= {rsh[DATA_W-2:0], 1'b0};
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
